// File: rtl/bp_dram_fixed_latency_pipe_pkg.sv
// bp_dram_fixed_latency_pipe_pkg
//   Shared constants and helpers for the fixed-latency DRAM timing model.
//   safe_clog2    : clog2 that never returns 0, so one-entry/one-element
//                   configurations still get a 1-bit index.
//   first_age_lp  : age a return entry carries when it first becomes visible.
//                   The read was accepted two edges earlier (issue edge, then
//                   the capture edge of the synchronous memory output).
package bp_dram_fixed_latency_pipe_pkg;

   localparam int first_age_lp = 2;

   function automatic int safe_clog2(input int x);
      int r;
      if (x <= 1) begin
         r = 1;
      end else begin
         r = $clog2(x);
      end
      return r;
   endfunction

endpackage

// File: rtl/bp_me_aging_fifo.sv
// bp_me_aging_fifo
//   Circular buffer of {addr, data} entries, each with an age counter that
//   counts up every cycle and saturates at latency_p. The head is reported
//   valid only once it has reached full age, which turns a plain in-order
//   queue into a fixed-latency return path.
//   Ports:
//     clk_i, reset_i : clock, async active-high reset (clears valids/pointers)
//     enq_v_i        : write enq_data_i into the tail slot
//     enq_data_i     : packed {addr, data} entry
//     deq_i          : pop the head (ignored unless v_o)
//     v_o            : head is valid and has reached latency_p
//     data_o         : head entry, stable until it is popped
//   The caller guarantees enq_v_i is never raised with all slots occupied.
module bp_me_aging_fifo
   import bp_dram_fixed_latency_pipe_pkg::*;
 #(parameter int width_p   = 8
   ,parameter int depth_p   = 4
   ,parameter int latency_p = 4
   )
  (input  logic               clk_i
   ,input  logic               reset_i
   ,input  logic               enq_v_i
   ,input  logic [width_p-1:0] enq_data_i
   ,input  logic               deq_i
   ,output logic               v_o
   ,output logic [width_p-1:0] data_o
   );

   localparam int ptr_w_lp = safe_clog2(depth_p);
   localparam int age_w_lp = safe_clog2(latency_p + 1);

   logic [width_p-1:0]  data_r [depth_p];
   logic [age_w_lp-1:0] age_r  [depth_p];
   logic [depth_p-1:0]  valid_r;
   logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
   logic [ptr_w_lp-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic                deq_s;

   assign v_o    = valid_r[rd_ptr_r] & (age_r[rd_ptr_r] == age_w_lp'(latency_p));
   assign data_o = data_r[rd_ptr_r];
   assign deq_s  = deq_i & v_o;

   // Pointer advance with explicit wrap, since depth_p need not be a power of 2.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (enq_v_i) begin
         wr_ptr_nxt_s = (wr_ptr_r == ptr_w_lp'(depth_p - 1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (deq_s) begin
         rd_ptr_nxt_s = (rd_ptr_r == ptr_w_lp'(depth_p - 1)) ? '0 : rd_ptr_r + ptr_w_lp'(1);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
   end

   // Control state: pointers, per-slot valid and saturating age.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_r  <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < depth_p; i++) begin
            age_r[i] <= '0;
         end
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         for (int i = 0; i < depth_p; i++) begin
            if (enq_v_i && (wr_ptr_r == ptr_w_lp'(i))) begin
               valid_r[i] <= 1'b1;
               age_r[i]   <= age_w_lp'(first_age_lp);
            end else if (deq_s && (rd_ptr_r == ptr_w_lp'(i))) begin
               valid_r[i] <= 1'b0;
               age_r[i]   <= '0;
            end else if (valid_r[i] && (age_r[i] < age_w_lp'(latency_p))) begin
               age_r[i]   <= age_r[i] + age_w_lp'(1);
            end else begin
               age_r[i]   <= age_r[i];
            end
         end
      end
   end

   // Payload storage; no reset needed because valid_r gates every use.
   always_ff @(posedge clk_i) begin
      if (enq_v_i) begin
         data_r[wr_ptr_r] <= enq_data_i;
      end
   end

endmodule

// File: rtl/bp_dram_fixed_latency_pipe.sv
// bp_dram_fixed_latency_pipe
//   Pipelined fixed-latency DRAM timing model between the DRAM side of
//   bp_mem_to_dram and a byte-masked 1rw synchronous memory. Accepts one
//   command per cycle, keeps up to max_reads_p reads in flight and returns
//   each read in order exactly read_latency_p cycles after acceptance,
//   holding the return stable under downstream backpressure.
//   Ports:
//     clk_i, reset_i                      : clock, async active-high reset
//     v_i, write_not_read_i, ch_addr_i    : command channel, yumi_o accepts
//     data_v_i, data_i, mask_i            : write data channel, data_yumi_o consumes
//     data_v_o, data_o, ch_addr_o         : read return, data_ready_and_i handshake
//     write_done_o                        : one-cycle pulse after each write accept
//     mem_v_o, mem_w_o, mem_addr_o,
//     mem_data_o, mem_w_mask_o            : memory access (combinational)
//     mem_data_i                          : memory read data, one cycle after access
module bp_dram_fixed_latency_pipe
   import bp_dram_fixed_latency_pipe_pkg::*;
 #(parameter int addr_width_p   = 40
   ,parameter int data_width_p   = 512
   ,parameter int mem_els_p      = 2048
   ,parameter int read_latency_p = 8
   ,parameter int max_reads_p    = 4
   ,localparam int lg_mem_els_lp   = safe_clog2(mem_els_p)
   ,localparam int block_offset_lp = safe_clog2(data_width_p / 8)
   )
  (input  logic                      clk_i
   ,input  logic                      reset_i
   ,input  logic                      v_i
   ,input  logic                      write_not_read_i
   ,input  logic [addr_width_p-1:0]   ch_addr_i
   ,output logic                      yumi_o
   ,input  logic                      data_v_i
   ,input  logic [data_width_p-1:0]   data_i
   ,input  logic [data_width_p/8-1:0] mask_i
   ,output logic                      data_yumi_o
   ,output logic                      data_v_o
   ,output logic [data_width_p-1:0]   data_o
   ,output logic [addr_width_p-1:0]   ch_addr_o
   ,input  logic                      data_ready_and_i
   ,output logic                      write_done_o
   ,output logic                      mem_v_o
   ,output logic                      mem_w_o
   ,output logic [lg_mem_els_lp-1:0]  mem_addr_o
   ,output logic [data_width_p-1:0]   mem_data_o
   ,output logic [data_width_p/8-1:0] mem_w_mask_o
   ,input  logic [data_width_p-1:0]   mem_data_i
   );

`ifndef SYNTHESIS
   if (read_latency_p < 2) begin : g_bad_latency
      $error("bp_dram_fixed_latency_pipe: read_latency_p must be >= 2");
   end
   if ((data_width_p % 8) != 0) begin : g_bad_width
      $error("bp_dram_fixed_latency_pipe: data_width_p must be a multiple of 8");
   end
   if (max_reads_p < 1) begin : g_bad_depth
      $error("bp_dram_fixed_latency_pipe: max_reads_p must be >= 1");
   end
`endif

   localparam int cnt_w_lp   = safe_clog2(max_reads_p + 1);
   localparam int entry_w_lp = addr_width_p + data_width_p;

   logic [cnt_w_lp-1:0]     out_cnt_r;
   logic                    rd_pending_r;
   logic [addr_width_p-1:0] rd_addr_r;
   logic                    write_done_r;
   logic                    read_accept_s, write_accept_s, deq_s, head_v_s;
   logic [entry_w_lp-1:0]   head_entry_s;

   // Credit check uses only the registered count; a same-cycle return does
   // not free a slot until the following cycle.
   assign read_accept_s  = v_i & ~write_not_read_i & ~reset_i & (out_cnt_r < cnt_w_lp'(max_reads_p));
   assign write_accept_s = v_i & write_not_read_i & data_v_i & ~reset_i;
   assign deq_s          = head_v_s & data_ready_and_i;

   assign yumi_o       = read_accept_s | write_accept_s;
   assign data_yumi_o  = write_accept_s;
   assign mem_v_o      = read_accept_s | write_accept_s;
   assign mem_w_o      = write_accept_s;
   assign mem_addr_o   = ch_addr_i[block_offset_lp +: lg_mem_els_lp];
   assign mem_data_o   = data_i;
   assign mem_w_mask_o = mask_i;

   assign data_v_o     = head_v_s;
   assign ch_addr_o    = head_entry_s[data_width_p +: addr_width_p];
   assign data_o       = head_entry_s[data_width_p-1:0];
   assign write_done_o = write_done_r;

   // Issue-stage registers: remember a read until memory data arrives, pulse
   // write_done, and track outstanding reads from accept to return handshake.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_pending_r <= 1'b0;
         rd_addr_r    <= '0;
         write_done_r <= 1'b0;
         out_cnt_r    <= '0;
      end else begin
         rd_pending_r <= read_accept_s;
         rd_addr_r    <= read_accept_s ? ch_addr_i : rd_addr_r;
         write_done_r <= write_accept_s;
         case ({read_accept_s, deq_s})
            2'b10:   out_cnt_r <= out_cnt_r + cnt_w_lp'(1);
            2'b01:   out_cnt_r <= out_cnt_r - cnt_w_lp'(1);
            default: out_cnt_r <= out_cnt_r;
         endcase
      end
   end

   bp_me_aging_fifo
    #(.width_p   (entry_w_lp)
      ,.depth_p   (max_reads_p)
      ,.latency_p (read_latency_p)
      )
    ret_fifo
     (.clk_i      (clk_i)
      ,.reset_i    (reset_i)
      ,.enq_v_i    (rd_pending_r)
      ,.enq_data_i ({rd_addr_r, mem_data_i})
      ,.deq_i      (deq_s)
      ,.v_o        (head_v_s)
      ,.data_o     (head_entry_s)
      );

endmodule

// File: tb/tb_bp_dram_fixed_latency_pipe.sv
// Self-checking bench for bp_dram_fixed_latency_pipe (latency 4, 5 reads).
// Reference: a shadow memory updated at command acceptance; each accepted
// read pushes {addr, data, issue cycle} into a scoreboard. A separate monitor
// checks that each return appears at max(issue+L, previous handshake+1) and
// carries the expected data and address.
module tb_bp_dram_fixed_latency_pipe;

   localparam int AW = 40;
   localparam int DW = 512;
   localparam int MW = DW / 8;
   localparam int ELS = 2048;
   localparam int L = 4;
   localparam int MAXR = 5;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            iss;
   } exp_t;

   logic clk, reset_i;
   logic v_i, write_not_read_i, data_v_i, data_ready_and_i;
   logic [AW-1:0] ch_addr_i, ch_addr_o;
   logic [DW-1:0] data_i, data_o, mem_data_o, mem_data_i;
   logic [MW-1:0] mask_i, mem_w_mask_o;
   logic yumi_o, data_yumi_o, data_v_o, write_done_o, mem_v_o, mem_w_o;
   logic [10:0] mem_addr_o;

   logic [DW-1:0] mem [ELS];
   logic [DW-1:0] shadow [ELS];
   logic          mem_init_done = 1'b0;

   exp_t sb [$];
   int   checks = 0, failures = 0;
   int   cyc = 0, iss_cnt = 0, hs_cnt = 0, last_hs = -100;
   logic prev_wr = 1'b0;

   bp_dram_fixed_latency_pipe #(
      .addr_width_p(AW), .data_width_p(DW), .mem_els_p(ELS),
      .read_latency_p(L), .max_reads_p(MAXR)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .write_not_read_i(write_not_read_i),
      .ch_addr_i(ch_addr_i), .yumi_o(yumi_o), .data_v_i(data_v_i), .data_i(data_i),
      .mask_i(mask_i), .data_yumi_o(data_yumi_o), .data_v_o(data_v_o), .data_o(data_o),
      .ch_addr_o(ch_addr_o), .data_ready_and_i(data_ready_and_i), .write_done_o(write_done_o),
      .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
   );

   function automatic logic [DW-1:0] init_word(input int i);
      logic [31:0] w;
      w = (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
      return {16{w}};
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int k = 0; k < 16; k++) w[32*k +: 32] = $urandom;
      return w;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Byte-masked 1rw synchronous memory behind the DUT.
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < ELS; i++) mem[i] <= init_word(i);
         mem_init_done <= 1'b1;
      end else if (mem_v_o) begin
         if (mem_w_o) begin
            for (int b = 0; b < MW; b++)
               if (mem_w_mask_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
         end else begin
            mem_data_i <= mem[mem_addr_o];
         end
      end
   end

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0b exp=%0b cycle=%0d", name, got, exp, cyc);
      end
   endtask

   // Return monitor: timing, data and address against the scoreboard head.
   initial begin
      int exp_cyc;
      forever begin
         @(negedge clk);
         if (!reset_i) begin
            if (sb.size() == 0) begin
               chk1("valid_when_empty", data_v_o, 1'b0);
            end else begin
               exp_cyc = sb[0].iss + L;
               if (last_hs + 1 > exp_cyc) exp_cyc = last_hs + 1;
               chk1("return_timing", data_v_o, (cyc >= exp_cyc));
               if (data_v_o === 1'b1) begin
                  checks++;
                  if (data_o !== sb[0].data) begin
                     failures++;
                     $display("FAIL ret_data got=%h exp=%h", data_o, sb[0].data);
                  end
                  checks++;
                  if (ch_addr_o !== sb[0].addr) begin
                     failures++;
                     $display("FAIL ret_addr got=%h exp=%h", ch_addr_o, sb[0].addr);
                  end
                  if (data_ready_and_i) begin
                     void'(sb.pop_front());
                     hs_cnt++;
                     last_hs = cyc;
                  end
               end
            end
         end
      end
   end

   // One command cycle: drive at posedge+1, check handshakes at negedge.
   task automatic step(input logic v, input logic wnr, input logic [AW-1:0] addr,
                       input logic dv, input logic [DW-1:0] d, input logic [MW-1:0] m,
                       input logic rdy, output logic acc);
      logic exp_rd, exp_wr;
      exp_t e;
      int idx;
      v_i = v; write_not_read_i = wnr; ch_addr_i = addr; data_v_i = dv;
      data_i = d; mask_i = m; data_ready_and_i = rdy;
      exp_rd = v && !wnr && ((iss_cnt - hs_cnt) < MAXR);
      exp_wr = v && wnr && dv;
      idx = int'(addr[6 +: 11]);
      @(negedge clk);
      chk1("yumi", yumi_o, exp_rd | exp_wr);
      chk1("data_yumi", data_yumi_o, exp_wr);
      chk1("write_done", write_done_o, prev_wr);
      chk1("mem_v", mem_v_o, exp_rd | exp_wr);
      chk1("mem_w", mem_w_o, exp_wr);
      if (exp_rd) begin
         e.addr = addr; e.data = shadow[idx]; e.iss = cyc;
         sb.push_back(e);
         iss_cnt++;
      end
      if (exp_wr) begin
         for (int b = 0; b < MW; b++)
            if (m[b]) shadow[idx][8*b +: 8] = d[8*b +: 8];
      end
      prev_wr = exp_wr;
      acc = exp_rd | exp_wr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0, rdy, a);
   endtask

   initial begin
      logic acc;
      logic [MW-1:0] full_m;
      full_m = '1;
      for (int i = 0; i < ELS; i++) shadow[i] = init_word(i);
      reset_i = 1'b1; v_i = 1'b1; write_not_read_i = 1'b1; data_v_i = 1'b1;
      ch_addr_i = '0; data_i = '0; mask_i = '1; data_ready_and_i = 1'b1;
      @(negedge clk);
      chk1("rst_data_v", data_v_o, 1'b0);
      chk1("rst_yumi", yumi_o, 1'b0);
      chk1("rst_data_yumi", data_yumi_o, 1'b0);
      chk1("rst_mem_v", mem_v_o, 1'b0);
      chk1("rst_write_done", write_done_o, 1'b0);
      @(posedge clk); #1;
      reset_i = 1'b0;
      idle(2, 1'b1);

      // Basic write then read.
      step(1'b1, 1'b1, 40'h40, 1'b1, {64{8'hA5}}, full_m, 1'b1, acc);
      idle(2, 1'b1);
      step(1'b1, 1'b0, 40'h40, 1'b0, '0, '0, 1'b1, acc);
      idle(6, 1'b1);
      // Masked write over an all-FF word.
      step(1'b1, 1'b1, 40'h100, 1'b1, {64{8'hFF}}, full_m, 1'b1, acc);
      step(1'b1, 1'b1, 40'h100, 1'b1, '0, 64'h000F, 1'b1, acc);
      step(1'b1, 1'b0, 40'h100, 1'b0, '0, '0, 1'b1, acc);
      // Write command with no data stalls; data without a write is not consumed.
      step(1'b1, 1'b1, 40'h140, 1'b0, '1, full_m, 1'b1, acc);
      step(1'b0, 1'b1, 40'h140, 1'b1, '1, full_m, 1'b1, acc);
      // Read-before-write hazard.
      step(1'b1, 1'b0, 40'h80, 1'b0, '0, '0, 1'b1, acc);
      step(1'b1, 1'b1, 40'h80, 1'b1, {64{8'h3C}}, full_m, 1'b1, acc);
      step(1'b1, 1'b0, 40'h80, 1'b0, '0, '0, 1'b1, acc);
      idle(8, 1'b1);

      // Streaming reads with ready held high.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 40'(i * 64), 1'b0, '0, '0, 1'b1, acc);
      idle(10, 1'b1);

      // Backpressure: 5 accepted, 6th refused until one return drains.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 40'(40'h200 + i * 64), 1'b0, '0, '0, 1'b0, acc);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 40'h380, 1'b0, '0, '0, 1'b0, acc);
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) step(1'b1, 1'b0, 40'h380, 1'b0, '0, '0, 1'b1, acc);
      chk1("bp_sixth_accepted", acc, 1'b1);
      idle(12, 1'b1);

      // Reset with reads in flight and a return stalled at the head.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 40'(40'h400 + i * 64), 1'b0, '0, '0, 1'b0, acc);
      idle(4, 1'b0);
      v_i = 1'b1; write_not_read_i = 1'b0; ch_addr_i = 40'h500; data_ready_and_i = 1'b0;
      #1 reset_i = 1'b1;
      #1;
      chk1("midrst_data_v", data_v_o, 1'b0);
      chk1("midrst_yumi", yumi_o, 1'b0);
      chk1("midrst_mem_v", mem_v_o, 1'b0);
      chk1("midrst_write_done", write_done_o, 1'b0);
      sb.delete();
      iss_cnt = 0; hs_cnt = 0; last_hs = -100; prev_wr = 1'b0;
      v_i = 1'b0;
      @(posedge clk); #1;
      reset_i = 1'b0;
      step(1'b1, 1'b0, 40'h40, 1'b0, '0, '0, 1'b1, acc);
      idle(8, 1'b1);

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              40'($urandom_range(0, 31) * 64), $urandom_range(0, 3) != 0,
              rand_word(), {$urandom, $urandom}, $urandom_range(0, 9) < 7, acc);
      end
      idle(30, 1'b1);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d exp=0 outstanding returns", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
